alu_issue: RTL

- Execute-entry stage that produces the ALU's operation interface.
- Decodes opcode/funct3/funct7 plus operand values into the one-hot op_type, op0 and op1 the ALU consumes.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between the decode/register-read stage and the ALU; the ALU's result is valid in the same cycle out_valid is high.

---
 rtl/alu_issue_pkg.sv | 78 +++++++
 rtl/alu_issue_dec.sv | 123 ++++++++++++
 rtl/alu_issue.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage.
// Optional feature: ALU_WORD_OP_EN (RV64 W-form ops; requires RV64).
package alu_issue_pkg;

`ifdef RV64
    localparam int unsigned XLEN = 64;
`else
    localparam int unsigned XLEN = 32;
`endif
    localparam int unsigned OPT_W     = 16;
    localparam int unsigned OPT_IDX_W = $clog2(OPT_W);

    // one-hot op_type bit positions
    localparam int unsigned OP_ADD_INDEX   = 0;
    localparam int unsigned OP_SUB_INDEX   = 1;
    localparam int unsigned OP_SLL_INDEX   = 2;
    localparam int unsigned OP_L_INDEX     = 3;
    localparam int unsigned OP_LU_INDEX    = 4;
    localparam int unsigned OP_XOR_INDEX   = 5;
    localparam int unsigned OP_SRL_INDEX   = 6;
    localparam int unsigned OP_SRA_INDEX   = 7;
    localparam int unsigned OP_OR_INDEX    = 8;
    localparam int unsigned OP_AND_INDEX   = 9;
    localparam int unsigned OP_EQ_INDEX    = 10;
    localparam int unsigned OP_NE_INDEX    = 11;
    localparam int unsigned OP_GE_INDEX    = 12;
    localparam int unsigned OP_GEU_INDEX   = 13;
    localparam int unsigned OP_LUI_INDEX   = 14;
    localparam int unsigned OP_AUIPC_INDEX = 15;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP32      = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32  = 7'b0011011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic            IS_WORD_OP = 1'b1;
    localparam logic [XLEN-1:0] ZERO       = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [OPT_W-1:0] op_type;
        logic [XLEN-1:0]  op0;
        logic [XLEN-1:0]  op1;
        logic             illegal;
`ifdef ALU_WORD_OP_EN
        logic             is_word_op;
`endif
    } alu_req_t;

    // funct3 to op_type index for the arithmetic groups; alt selects SUB/SRA
    function automatic logic [OPT_IDX_W-1:0] alu_idx(input logic [2:0] f3, input logic alt);
        logic [OPT_IDX_W-1:0] idx;
        idx = OPT_IDX_W'(OP_ADD_INDEX);
        case (f3)
            3'b000:  idx = alt ? OPT_IDX_W'(OP_SUB_INDEX) : OPT_IDX_W'(OP_ADD_INDEX);
            3'b001:  idx = OPT_IDX_W'(OP_SLL_INDEX);
            3'b010:  idx = OPT_IDX_W'(OP_L_INDEX);
            3'b011:  idx = OPT_IDX_W'(OP_LU_INDEX);
            3'b100:  idx = OPT_IDX_W'(OP_XOR_INDEX);
            3'b101:  idx = alt ? OPT_IDX_W'(OP_SRA_INDEX) : OPT_IDX_W'(OP_SRL_INDEX);
            3'b110:  idx = OPT_IDX_W'(OP_OR_INDEX);
            default: idx = OPT_IDX_W'(OP_AND_INDEX);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational decoder: opcode/funct fields and operands to ALU request.
// Optional feature: ALU_WORD_OP_EN adds OP-32 / OP-IMM-32 decode.
module alu_issue_dec
    import alu_issue_pkg::*;
(
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output alu_req_t        req_c
);

    logic                 legal;
    logic [OPT_IDX_W-1:0] idx;
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [6:0]           f7_imm;
`ifdef ALU_WORD_OP_EN
    logic                 word;
`endif

    // Decode legality, op index and operand sources
    always_comb begin
        legal = 1'b0;
        idx   = '0;
        a     = ZERO;
        b     = ZERO;
`ifdef ALU_WORD_OP_EN
        word  = ~IS_WORD_OP;
`endif
`ifdef RV64
        f7_imm = {funct7[6:1], 1'b0};
`else
        f7_imm = funct7;
`endif
        case (opcode)
            OPC_OP: begin
                a     = rs1_val;
                b     = rs2_val;
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                idx   = alu_idx(funct3, funct7[5]);
            end
            OPC_OP_IMM: begin
                a = rs1_val;
                b = imm;
                case (funct3)
                    3'b001:  legal = (f7_imm == F7_BASE);
                    3'b101:  legal = (f7_imm == F7_BASE) || (f7_imm == F7_ALT);
                    default: legal = 1'b1;
                endcase
                idx = alu_idx(funct3, (funct3 == 3'b101) && f7_imm[5]);
            end
            OPC_BRANCH: begin
                a     = rs1_val;
                b     = rs2_val;
                legal = 1'b1;
                case (funct3)
                    3'b000:  idx = OPT_IDX_W'(OP_EQ_INDEX);
                    3'b001:  idx = OPT_IDX_W'(OP_NE_INDEX);
                    3'b100:  idx = OPT_IDX_W'(OP_L_INDEX);
                    3'b101:  idx = OPT_IDX_W'(OP_GE_INDEX);
                    3'b110:  idx = OPT_IDX_W'(OP_LU_INDEX);
                    3'b111:  idx = OPT_IDX_W'(OP_GEU_INDEX);
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                b     = imm;
                idx   = OPT_IDX_W'(OP_LUI_INDEX);
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                a     = pc;
                b     = imm;
                idx   = OPT_IDX_W'(OP_AUIPC_INDEX);
            end
`ifdef ALU_WORD_OP_EN
            OPC_OP32: begin
                a     = rs1_val;
                b     = rs2_val;
                word  = IS_WORD_OP;
                legal = ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101)) &&
                        ((funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && (funct3 != 3'b001)));
                idx   = alu_idx(funct3, funct7[5]);
            end
            OPC_OP_IMM32: begin
                a    = rs1_val;
                b    = imm;
                word = IS_WORD_OP;
                case (funct3)
                    3'b000:  legal = 1'b1;
                    3'b001:  legal = (funct7 == F7_BASE);
                    3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: legal = 1'b0;
                endcase
                idx = alu_idx(funct3, (funct3 == 3'b101) && funct7[5]);
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    // Illegal entries carry a zero payload and only the illegal flag
    always_comb begin
        req_c         = '0;
        req_c.illegal = ~legal;
        if (legal) begin
            req_c.op_type = OPT_W'(1) << idx;
            req_c.op0     = a;
            req_c.op1     = b;
        end
`ifdef ALU_WORD_OP_EN
        req_c.is_word_op = legal ? word : ~IS_WORD_OP;
`endif
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decoder feeding a two-entry (output + skid) handshake buffer.
// Optional feature: ALU_WORD_OP_EN adds the is_word_op output and W-form decode.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPT_W-1:0] op_type,
    output logic [XLEN-1:0]  op0,
    output logic [XLEN-1:0]  op1,
    output logic             illegal
`ifdef ALU_WORD_OP_EN
    ,
    output logic             is_word_op
`endif
);

    buf_state_t state;
    buf_state_t state_nxt;
    alu_req_t   dec_c;
    alu_req_t   out_q;
    alu_req_t   skid_q;
    logic       accept_c;
    logic       consume_c;
    logic       load_out_in_c;
    logic       load_out_skid_c;
    logic       load_skid_c;

    alu_issue_dec u_dec (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .imm     (imm),
        .pc      (pc),
        .req_c   (dec_c)
    );

    // A flush cycle never accepts; in_ready is already low when FULL
    assign accept_c  = in_valid && in_ready && !flush;
    assign consume_c = out_valid && out_ready;

    // Buffer occupancy state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and data-movement selects
    always_comb begin
        state_nxt       = state;
        load_out_in_c   = 1'b0;
        load_out_skid_c = 1'b0;
        load_skid_c     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept_c) begin
                    state_nxt     = ST_ONE;
                    load_out_in_c = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept_c && consume_c) begin
                    load_out_in_c = 1'b1;
                end else if (accept_c) begin
                    state_nxt   = ST_FULL;
                    load_skid_c = 1'b1;
                end else if (consume_c) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume_c) begin
                    state_nxt       = ST_ONE;
                    load_out_skid_c = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt       = ST_EMPTY;
            load_out_skid_c = 1'b0;
        end
    end

    // Output/skid payload registers and registered handshake flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_q     <= '0;
            skid_q    <= '0;
        end else begin
            out_valid <= (state_nxt != ST_EMPTY);
            in_ready  <= (state_nxt != ST_FULL);
            if (load_out_in_c) begin
                out_q <= dec_c;
            end else if (load_out_skid_c) begin
                out_q <= skid_q;
            end
            if (load_skid_c) begin
                skid_q <= dec_c;
            end
        end
    end

    assign op_type = out_q.op_type;
    assign op0     = out_q.op0;
    assign op1     = out_q.op1;
    assign illegal = out_q.illegal;
`ifdef ALU_WORD_OP_EN
    assign is_word_op = out_q.is_word_op;
`endif

endmodule
